irq_eoi_ctrl: RTL and testbench

- SOC-side responder for the chip's 16-line IRQ/EOI pad interface.
- Takes the raw `irq[15:0]` nets from the input pads and synchronises them. Latches rising edges as pending interrupts.
- Presents the highest-priority pending interrupt to the core over a valid/ready claim handshake.
- When the core signals completion, drives a fixed-width `eoi[id]` pulse back out through the output pads.

---
 rtl/irq_eoi_ctrl_pkg.sv | 20 ++
 rtl/irq_eoi_ctrl_if.sv | 37 +++
 rtl/irq_eoi_ctrl_eoi_pulse_gen.sv | 75 +++++++
 rtl/irq_eoi_ctrl.sv | 118 +++++++++++
 tb/tb_irq_eoi_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_eoi_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : irq_pkg
// Brief   : Shared defaults and types for the IRQ/EOI pad responder.
// Revision: 1.0
// ---------------------------------------------------------------------------
package irq_pkg;

  localparam int DEF_N_IRQ = 16;
  localparam int DEF_ID_W  = $clog2(DEF_N_IRQ);

  typedef logic [DEF_ID_W-1:0] irq_id_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } eoi_state_t;

endpackage
`default_nettype wire

// File: rtl/irq_eoi_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : irq_eoi_ctrl_if
// Brief   : Claim and completion handshakes between the core and the IRQ/EOI responder.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface irq_eoi_ctrl_if;
  import irq_pkg::*;

  logic    claim_valid;
  irq_id_t claim_id;
  logic    claim_ready;
  logic    done_valid;
  irq_id_t done_id;
  logic    done_ready;

  // master = core side, slave = controller side
  modport master (
    input  claim_valid,
    input  claim_id,
    output claim_ready,
    output done_valid,
    output done_id,
    input  done_ready
  );

  modport slave (
    output claim_valid,
    output claim_id,
    input  claim_ready,
    input  done_valid,
    input  done_id,
    output done_ready
  );

endinterface
`default_nettype wire

// File: rtl/irq_eoi_ctrl_eoi_pulse_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : eoi_pulse_gen
// Brief   : One-at-a-time EOI pulse FSM; drives eoi[id] for EOI_CYCLES clocks.
// Revision: 1.0
// ---------------------------------------------------------------------------
module eoi_pulse_gen
  import irq_pkg::*;
#(
  parameter int N_IRQ      = DEF_N_IRQ,
  parameter int ID_W       = DEF_ID_W,
  parameter int EOI_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ID_W-1:0]  id,
  output logic [N_IRQ-1:0] eoi,
  output logic             ready,
  output logic             finish,
  output logic [ID_W-1:0]  finish_id
);

  localparam int CNT_W = (EOI_CYCLES > 1) ? $clog2(EOI_CYCLES) : 1;

  eoi_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [ID_W-1:0]  r_id, w_id_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_id    <= w_id_nxt;
    end
  end

  // eoi is decoded from state so an async reset drops it in the same instant
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_id_nxt    = r_id;
    eoi         = '0;
    ready       = 1'b0;
    finish      = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_state_nxt = PULSE;
          w_id_nxt    = id;
          w_cnt_nxt   = CNT_W'(EOI_CYCLES - 1);
        end
      end
      PULSE: begin
        eoi = N_IRQ'(1) << r_id;
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
          finish      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign finish_id = r_id;

endmodule
`default_nettype wire

// File: rtl/irq_eoi_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : irq_eoi_ctrl
// Brief   : Synchronises pad IRQs, latches edges, arbitrates claims, issues EOI pulses.
// Revision: 1.0
// ---------------------------------------------------------------------------
module irq_eoi_ctrl
  import irq_pkg::*;
#(
  parameter int N_IRQ       = DEF_N_IRQ,
  parameter int ID_W        = DEF_ID_W,
  parameter int SYNC_STAGES = 2,
  parameter int EOI_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic [N_IRQ-1:0] irq_mask,
  irq_eoi_ctrl_if.slave    bus,
  output logic [N_IRQ-1:0] eoi,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] in_service,
  output logic             done_err
);

  logic [N_IRQ-1:0] w_edge;
  logic [N_IRQ-1:0] r_pending, r_in_service;
  logic [N_IRQ-1:0] w_eligible, w_claim_set, w_fin_clr;
  logic [ID_W-1:0]  w_pick_id, r_claim_id, w_done_id, w_finish_id;
  logic             w_any, r_claim_valid, w_claim_fire;
  logic             w_done_fire, w_done_ok, w_start, w_finish, r_done_err;

  for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync <= '0;
        r_dly  <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], irq[i]};
        r_dly  <= r_sync[SYNC_STAGES-1];
      end
    end

    assign w_edge[i] = r_sync[SYNC_STAGES-1] & ~r_dly;
  end

  assign w_eligible = r_pending & ~irq_mask & ~r_in_service;
  assign w_any      = |w_eligible;

  // Descending scan so the lowest set index is the last one written
  always_comb begin
    w_pick_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_pick_id = ID_W'(i);
    end
  end

  assign w_claim_fire = r_claim_valid & bus.claim_ready;
  assign w_claim_set  = w_claim_fire ? (N_IRQ'(1) << r_claim_id) : '0;

  // An offer is frozen until taken; after a take the idle cycle re-arbitrates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_claim_valid <= 1'b0;
      r_claim_id    <= '0;
    end else if (r_claim_valid) begin
      if (bus.claim_ready) r_claim_valid <= 1'b0;
    end else begin
      r_claim_valid <= w_any;
      r_claim_id    <= w_pick_id;
    end
  end

  assign w_done_id   = bus.done_id;
  assign w_done_fire = bus.done_valid & bus.done_ready;
  assign w_done_ok   = ({1'b0, w_done_id} < (ID_W + 1)'(N_IRQ)) && r_in_service[w_done_id];
  assign w_start     = w_done_fire & w_done_ok;
  assign w_fin_clr   = w_finish ? (N_IRQ'(1) << w_finish_id) : '0;

  // New edges override a same-cycle claim clear so no interrupt is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending    <= '0;
      r_in_service <= '0;
      r_done_err   <= 1'b0;
    end else begin
      r_pending    <= (r_pending & ~w_claim_set) | w_edge;
      r_in_service <= (r_in_service & ~w_fin_clr) | w_claim_set;
      r_done_err   <= w_done_fire & ~w_done_ok;
    end
  end

  eoi_pulse_gen #(
    .N_IRQ      (N_IRQ),
    .ID_W       (ID_W),
    .EOI_CYCLES (EOI_CYCLES)
  ) u_eoi_pulse_gen (
    .clk       (clk),
    .rst       (rst),
    .start     (w_start),
    .id        (w_done_id),
    .eoi       (eoi),
    .ready     (bus.done_ready),
    .finish    (w_finish),
    .finish_id (w_finish_id)
  );

  assign bus.claim_valid = r_claim_valid;
  assign bus.claim_id    = r_claim_id;
  assign pending         = r_pending;
  assign in_service      = r_in_service;
  assign done_err        = r_done_err;

endmodule
`default_nettype wire

// File: tb/tb_irq_eoi_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_irq_eoi_ctrl
// Brief   : Directed self-checking bench for irq_eoi_ctrl.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_irq_eoi_ctrl;
  import irq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] irq, irq_mask, eoi, pending, in_service;
  logic        done_err;
  int          checks   = 0;
  int          failures = 0;

  irq_eoi_ctrl_if bus();

  irq_eoi_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .irq_mask   (irq_mask),
    .bus        (bus),
    .eoi        (eoi),
    .pending    (pending),
    .in_service (in_service),
    .done_err   (done_err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_claim(input string tag, input logic [3:0] exp_id);
    int n = 0;
    while (!bus.claim_valid && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(bus.claim_valid), 32'd1);
    check({tag, "_id"}, 32'(bus.claim_id), 32'(exp_id));
  endtask

  task automatic take_claim();
    bus.claim_ready = 1'b1;
    tick();
    bus.claim_ready = 1'b0;
  endtask

  task automatic finish_eoi(input logic [3:0] id);
    int n = 0;
    while (!bus.done_ready && n < 10) begin
      tick();
      n++;
    end
    bus.done_valid = 1'b1;
    bus.done_id    = id;
    tick();
    bus.done_valid = 1'b0;
    tick(4);
  endtask

  initial begin
    rst             = 1'b1;
    irq             = '0;
    irq_mask        = '0;
    bus.claim_ready = 1'b0;
    bus.done_valid  = 1'b0;
    bus.done_id     = '0;
    tick(2);
    check("rst_claim_valid", 32'(bus.claim_valid), 32'd0);
    check("rst_done_ready", 32'(bus.done_ready), 32'd1);
    check("rst_eoi", 32'(eoi), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_in_service", 32'(in_service), 32'd0);
    check("rst_done_err", 32'(done_err), 32'd0);
    rst = 1'b0;
    tick(2);

    // irq[5] edge latency, offer held through a higher-priority arrival
    irq = 16'h0020;
    tick(2);
    check("t1_pend_e1", 32'(pending), 32'h0000);
    tick();
    check("t1_pend_e2", 32'(pending), 32'h0020);
    check("t1_valid_e2", 32'(bus.claim_valid), 32'd0);
    tick();
    check("t1_valid_e3", 32'(bus.claim_valid), 32'd1);
    check("t1_id_e3", 32'(bus.claim_id), 32'd5);
    tick(2);
    irq = 16'h0024;
    tick(4);
    check("t1_pend_both", 32'(pending), 32'h0024);
    check("t1_id_held", 32'(bus.claim_id), 32'd5);
    check("t1_valid_held", 32'(bus.claim_valid), 32'd1);
    take_claim();
    check("t1_pend_after", 32'(pending), 32'h0004);
    check("t1_insvc_after", 32'(in_service), 32'h0020);
    check("t1_gap", 32'(bus.claim_valid), 32'd0);
    tick();
    check("t1_next_valid", 32'(bus.claim_valid), 32'd1);
    check("t1_next_id", 32'(bus.claim_id), 32'd2);
    take_claim();
    check("t1_insvc_2", 32'(in_service), 32'h0024);
    finish_eoi(4'd5);
    finish_eoi(4'd2);
    check("t1_insvc_clear", 32'(in_service), 32'h0000);

    // simultaneous edges: lowest id first; masked line stays pending
    irq = '0;
    tick(3);
    irq = 16'h0208;
    wait_claim("t2_first", 4'd3);
    take_claim();
    tick();
    check("t2_second_valid", 32'(bus.claim_valid), 32'd1);
    check("t2_second_id", 32'(bus.claim_id), 32'd9);
    take_claim();
    finish_eoi(4'd3);
    finish_eoi(4'd9);
    irq      = '0;
    irq_mask = 16'h0008;
    tick(3);
    irq = 16'h0208;
    wait_claim("t2_masked", 4'd9);
    take_claim();
    tick();
    check("t2_mask_pend", 32'(pending), 32'h0008);
    check("t2_mask_novalid", 32'(bus.claim_valid), 32'd0);
    finish_eoi(4'd9);
    irq_mask = '0;
    wait_claim("t2_unmask", 4'd3);
    take_claim();
    finish_eoi(4'd3);

    // full EOI pulse on id 7
    irq = '0;
    tick(3);
    irq = 16'h0080;
    wait_claim("t3_claim", 4'd7);
    take_claim();
    check("t3_insvc", 32'(in_service), 32'h0080);
    check("t3_ready_pre", 32'(bus.done_ready), 32'd1);
    bus.done_valid = 1'b1;
    bus.done_id    = 4'd7;
    tick();
    bus.done_valid = 1'b0;
    check("t3_eoi_c1", 32'(eoi), 32'h0080);
    check("t3_ready_c1", 32'(bus.done_ready), 32'd0);
    tick(2);
    check("t3_eoi_c3", 32'(eoi), 32'h0080);
    tick();
    check("t3_eoi_c4", 32'(eoi), 32'h0080);
    check("t3_insvc_c4", 32'(in_service), 32'h0080);
    tick();
    check("t3_eoi_end", 32'(eoi), 32'h0000);
    check("t3_insvc_end", 32'(in_service), 32'h0000);
    check("t3_ready_end", 32'(bus.done_ready), 32'd1);

    // completion for a line not in service is rejected
    bus.done_valid = 1'b1;
    bus.done_id    = 4'd4;
    tick();
    bus.done_valid = 1'b0;
    check("t4_err", 32'(done_err), 32'd1);
    check("t4_eoi", 32'(eoi), 32'h0000);
    check("t4_ready", 32'(bus.done_ready), 32'd1);
    tick();
    check("t4_err_clear", 32'(done_err), 32'd0);

    // claim of id 1 coincides with a fresh irq[1] edge
    irq = '0;
    tick(3);
    irq = 16'h0002;
    wait_claim("t5_claim", 4'd1);
    irq = '0;
    tick(3);
    irq = 16'h0002;
    tick(2);
    bus.claim_ready = 1'b1;
    tick();
    bus.claim_ready = 1'b0;
    check("t5_pend", 32'(pending), 32'h0002);
    check("t5_insvc", 32'(in_service), 32'h0002);
    tick(3);
    check("t5_no_reoffer", 32'(bus.claim_valid), 32'd0);
    finish_eoi(4'd1);
    check("t5_still_none", 32'(bus.claim_valid), 32'd0);
    tick();
    check("t5_reoffer_valid", 32'(bus.claim_valid), 32'd1);
    check("t5_reoffer_id", 32'(bus.claim_id), 32'd1);
    take_claim();
    finish_eoi(4'd1);

    // reset in the middle of an eoi[6] pulse
    irq = '0;
    tick(3);
    irq = 16'h0040;
    wait_claim("t6_claim", 4'd6);
    take_claim();
    bus.done_valid = 1'b1;
    bus.done_id    = 4'd6;
    tick();
    bus.done_valid = 1'b0;
    tick();
    check("t6_eoi_c2", 32'(eoi), 32'h0040);
    rst = 1'b1;
    #1;
    check("t6_rst_eoi", 32'(eoi), 32'h0000);
    check("t6_rst_pend", 32'(pending), 32'h0000);
    check("t6_rst_insvc", 32'(in_service), 32'h0000);
    check("t6_rst_valid", 32'(bus.claim_valid), 32'd0);
    check("t6_rst_ready", 32'(bus.done_ready), 32'd1);
    irq = '0;
    tick(2);
    rst = 1'b0;
    tick(3);
    irq = 16'h0040;
    tick(3);
    check("t6_post_valid_e2", 32'(bus.claim_valid), 32'd0);
    check("t6_post_pend", 32'(pending), 32'h0040);
    tick();
    check("t6_post_valid", 32'(bus.claim_valid), 32'd1);
    check("t6_post_id", 32'(bus.claim_id), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
